ddr_rx_word_aligner: RTL and testbench
======================================

Name: ddr_rx_word_aligner

Overview:
- Consumes the per-lane rising/falling-edge sample pairs produced by the I_DDR capture stage.
- Each lane's bit stream is deserialized into WORD_W-bit words.
- Word boundaries are aligned on a sync pattern detected on lane 0.
- Aligned multi-lane words are presented to the fabric over a valid/ready interface through a 2-entry FIFO.
- Sits directly downstream of the I_BUF -> I_DDR input path, in place of the per-bit DFFRE retiming.

Parameters:
- NUM_LANES, 3, number of DDR input lanes.
- WORD_W, 8, bits per lane word; must be even and >= 4.
- SYNC_PAT, 8'hA5, WORD_W-bit alignment/idle pattern, lane 0 only.

Ports:
- clk  input  1  single clock; shared with the I_DDR capture clock.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  sample pair valid this cycle; when low, nothing shifts.
- d_rise  input  NUM_LANES  rising-edge sample per lane; earlier in time than d_fall.
- d_fall  input  NUM_LANES  falling-edge sample per lane.
- realign  input  1  single-cycle pulse; returns the block to SEARCH.
- out_data  output  NUM_LANES*WORD_W  lane k in bits [k*WORD_W +: WORD_W]; first-received bit is the MSB.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head when out_valid && out_ready.
- locked  output  1  high in LOCKED.
- overflow  output  1  sticky; a word was dropped because the FIFO was full.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (rst low, asynchronous):
  - shift registers, phase counter and FIFO cleared.
  - state = SEARCH.
  - out_valid=0, out_data=0, locked=0, overflow=0.
- Shift register, per lane, 2*WORD_W bits:
  - On a clock edge with in_valid=1: sr <= {sr[2W-3:0], d_rise[k], d_fall[k]}. The newest bit is the LSB.
  - Window offset 0 = sr[W-1:0]; window offset 1 = sr[W:1].
  - With in_valid=0: sr, phase counter and state all hold.
- State SEARCH (locked=0, no words pushed):
  - Each cycle after a shift, compare lane-0 windows against SYNC_PAT.
  - Offset 0 match takes priority over offset 1.
  - On a match: register the offset, clear the phase counter, move to LOCKED.
  - The sync word itself is not pushed.
- State LOCKED (locked=1):
  - The phase counter increments on each valid sample.
  - When it reaches WORD_W/2, a full word is present in every lane's window at the stored offset and the counter wraps to 0.
  - If lane 0 of that word == SYNC_PAT, the word is an idle and is discarded.
  - Otherwise the word is pushed into the FIFO.
- Latency:
  - The sample completing a word is registered at edge N.
  - The push occurs at edge N+1.
  - out_valid is high after edge N+1 when the FIFO was empty.
- FIFO, 2 entries, first-word fall-through:
  - Pop on out_valid && out_ready.
  - Simultaneous push and pop when full: allowed, no drop.
  - Push when full without a pop: word dropped, overflow <= 1.
  - overflow clears only on clear_overflow. If a drop and clear_overflow occur in the same cycle, overflow = 1 (set wins).
- realign:
  - Sampled in any state.
  - Next cycle: state = SEARCH, phase counter = 0, locked = 0.
  - FIFO contents are retained and continue to drain.
  - A word completing in the same cycle as realign is not pushed.
- Reset mid-operation: immediate return to the reset values above. FIFO contents are lost.
- out_data is stable while out_valid=1 and out_ready=0.

Test Plan:
- Reset: hold rst=0 with random inputs -> out_valid=0, locked=0, overflow=0. Release, then send lane-0 bits not containing 8'hA5 for 20 cycles -> locked stays 0, no out_valid.
- Offset-0 lock: stream A5 then 3C on lane 0 and 11/22 on lanes 1/2, even-aligned -> locked rises after the 4th sample of A5. out_valid 2 cycles after the 4th sample of the next word; out_data = {lane2 22, lane1 11, lane0 3C}.
- Offset-1 lock: same stream preceded by one extra bit -> lock with offset 1; identical out_data.
- Idle drop and backpressure: in LOCKED send 3C, A5, 5A, 77 with out_ready=0 -> A5 not stored. 3C and 5A fill the FIFO; 77 dropped; overflow=1. Then raise out_ready -> 3C then 5A delivered; clear_overflow -> overflow=0.
- in_valid gaps: insert in_valid=0 cycles between samples of a word -> output word unchanged; latency measured from the final valid sample stays 2 cycles.
- realign and mid-operation reset:
  - realign pulse with one word in the FIFO -> locked=0 next cycle, FIFO word still delivered, relock on the next A5.
  - rst asserted with out_valid=1 -> out_valid=0 immediately.

Source files
------------

// File: rtl/ddr_rx_word_aligner_if.sv
// ddr_rx_word_aligner_if
//   Groups the sample input path and the valid/ready word output of the
//   DDR receive word aligner.
//   Ports (signals):
//     in_valid  : a rising/falling sample pair is present this cycle
//     d_rise    : rising-edge sample per lane (earlier in time)
//     d_fall    : falling-edge sample per lane
//     out_data  : aligned word, lane k in [k*WORD_W +: WORD_W]
//     out_valid : output FIFO head is valid
//     out_ready : consumer accepts the head word
//   Modports:
//     master : the side that supplies samples and consumes words
//     slave  : the aligner itself
`timescale 1ns/1ps
interface ddr_rx_word_aligner_if #(
  parameter int NUM_LANES = 3,
  parameter int WORD_W    = 8
);
  logic                          in_valid;
  logic [NUM_LANES-1:0]          d_rise;
  logic [NUM_LANES-1:0]          d_fall;
  logic [NUM_LANES*WORD_W-1:0]   out_data;
  logic                          out_valid;
  logic                          out_ready;

  modport master (
    output in_valid, d_rise, d_fall, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  in_valid, d_rise, d_fall, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/ddr_rx_word_aligner.sv
// ddr_rx_word_aligner
//   Deserializes per-lane DDR sample pairs into WORD_W-bit words, finds the
//   word boundary from SYNC_PAT on lane 0 and hands aligned multi-lane words
//   to the fabric through a 2-entry first-word-fall-through FIFO.
//   Ports:
//     clk            : single clock, shared with the I_DDR capture clock
//     rst_n          : asynchronous active-low reset
//     bus            : sample input and valid/ready word output (slave)
//     realign        : single-cycle pulse, returns to SEARCH
//     clear_overflow : synchronous clear of the sticky overflow flag
//     locked         : high while word alignment is held
//     overflow       : sticky, a word was dropped on a full FIFO
`timescale 1ns/1ps
module ddr_rx_word_aligner #(
  parameter int                NUM_LANES = 3,
  parameter int                WORD_W    = 8,
  parameter logic [WORD_W-1:0] SYNC_PAT  = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ddr_rx_word_aligner_if.slave  bus,
  input  logic                  realign,
  input  logic                  clear_overflow,
  output logic                  locked,
  output logic                  overflow
);

  localparam int SR_W   = 2 * WORD_W;
  localparam int HALF   = WORD_W / 2;
  localparam int PH_W   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DATA_W = NUM_LANES * WORD_W;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF - 1);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t              state;
  logic [SR_W-1:0]     sr      [NUM_LANES];
  logic [SR_W-1:0]     sr_next [NUM_LANES];
  logic                offset;
  logic [PH_W-1:0]     phase;
  logic [DATA_W-1:0]   cap_word;
  logic [DATA_W-1:0]   word_reg;
  logic                word_pend;
  logic                match0;
  logic                match1;
  // The oldest two bits only age out of the register and are never looked at.
  logic [NUM_LANES-1:0] sr_unused;

  // Decisions are taken on the shift register as it will look after this
  // edge's sample, so a word finished at edge N is captured at edge N and
  // pushed at N+1.
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      sr_next[k] = {sr[k][SR_W-3:0], bus.d_rise[k], bus.d_fall[k]};
      cap_word[k*WORD_W +: WORD_W] = offset ? sr_next[k][WORD_W:1]
                                            : sr_next[k][WORD_W-1:0];
      sr_unused[k] = ^sr[k][SR_W-1:SR_W-2];
    end
  end

  assign match0 = (sr_next[0][WORD_W-1:0] == SYNC_PAT);
  assign match1 = (sr_next[0][WORD_W:1]   == SYNC_PAT);

  // Alignment FSM. realign wins over everything, including a word that
  // completes in the same cycle, which is therefore never pushed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_LANES; k++) sr[k] <= '0;
      state     <= SEARCH;
      locked    <= 1'b0;
      offset    <= 1'b0;
      phase     <= '0;
      word_pend <= 1'b0;
      word_reg  <= '0;
    end else begin
      word_pend <= 1'b0;
      if (bus.in_valid) begin
        for (int k = 0; k < NUM_LANES; k++) sr[k] <= sr_next[k];
      end
      if (realign) begin
        state  <= SEARCH;
        locked <= 1'b0;
        phase  <= '0;
      end else if (bus.in_valid) begin
        case (state)
          SEARCH: begin
            // Offset 0 has priority, hence offset = !match0 when either hits.
            if (match0 || match1) begin
              offset <= !match0;
              phase  <= '0;
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (phase == PH_LAST) begin
              phase <= '0;
              // A lane-0 sync pattern at a word boundary is an idle.
              if (cap_word[WORD_W-1:0] != SYNC_PAT) begin
                word_pend <= 1'b1;
                word_reg  <= cap_word;
              end
            end else begin
              phase <= phase + 1'b1;
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  logic [DATA_W-1:0] mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;
  logic              pop;
  logic              full;
  logic              do_push;
  logic              drop;

  // A push into a full FIFO still succeeds when the head leaves in the same
  // cycle; the write slot is then the one being vacated.
  assign pop     = bus.out_valid && bus.out_ready;
  assign full    = (count == 2'd2);
  assign do_push = word_pend && (!full || pop);
  assign drop    = word_pend && full && !pop;

  // Output FIFO and sticky overflow; a drop wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0]   <= '0;
      mem[1]   <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      overflow <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= word_reg;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({do_push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

  assign bus.out_valid = (count != 2'd0);
  assign bus.out_data  = mem[rd_ptr];

endmodule

// File: tb/tb_ddr_rx_word_aligner.sv
// tb_ddr_rx_word_aligner
//   Directed and randomized stimulus for ddr_rx_word_aligner, checked every
//   cycle against a bit-stream reference model: the model keeps the full
//   received bit history per lane and locates sync patterns and word
//   boundaries by bit index, and keeps the output FIFO as a plain queue.
`timescale 1ns/1ps
module tb_ddr_rx_word_aligner;

  localparam int NL = 3;
  localparam int W  = 8;
  localparam logic [W-1:0] SYNC = 8'hA5;

  logic clk = 1'b0;
  logic rst_n;
  logic realign;
  logic clear_overflow;
  logic locked;
  logic overflow;

  ddr_rx_word_aligner_if #(.NUM_LANES(NL), .WORD_W(W)) bus ();

  ddr_rx_word_aligner #(.NUM_LANES(NL), .WORD_W(W), .SYNC_PAT(SYNC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus.slave),
    .realign        (realign),
    .clear_overflow (clear_overflow),
    .locked         (locked),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  bit cur_ready = 1'b0;
  bit cur_clear = 1'b0;
  bit lane_q [NL][$];

  bit                 hist [NL][$];
  bit                 m_locked;
  int                 m_offset;
  int                 m_next_end;
  bit                 m_pend;
  logic [NL*W-1:0]    m_pend_word;
  logic [NL*W-1:0]    m_fifo [$];
  bit                 m_overflow;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] bits_at(input int k, input int start);
    logic [W-1:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v = {v[W-2:0], hist[k][start+i]};
    return v;
  endfunction

  // History starts with W+1 zeros, matching the cleared shift registers.
  task automatic model_reset();
    for (int k = 0; k < NL; k++) begin
      hist[k].delete();
      for (int i = 0; i < W + 1; i++) hist[k].push_back(1'b0);
    end
    m_locked   = 1'b0;
    m_offset   = 0;
    m_next_end = 0;
    m_pend     = 1'b0;
    m_pend_word = '0;
    m_fifo.delete();
    m_overflow = 1'b0;
  endtask

  task automatic model_edge();
    bit              pop;
    bit              drop;
    bit              new_pend;
    logic [NL*W-1:0] word;
    int              n;
    pop  = (m_fifo.size() != 0) && bus.out_ready;
    drop = m_pend && (m_fifo.size() == 2) && !pop;
    if (pop) void'(m_fifo.pop_front());
    if (m_pend && !drop) m_fifo.push_back(m_pend_word);
    if (drop) m_overflow = 1'b1;
    else if (clear_overflow) m_overflow = 1'b0;
    new_pend = 1'b0;
    word = '0;
    if (bus.in_valid) begin
      for (int k = 0; k < NL; k++) begin
        hist[k].push_back(bus.d_rise[k]);
        hist[k].push_back(bus.d_fall[k]);
      end
    end
    n = hist[0].size();
    if (realign) begin
      m_locked = 1'b0;
    end else if (bus.in_valid) begin
      if (!m_locked) begin
        if (bits_at(0, n - W) == SYNC) begin
          m_locked = 1'b1; m_offset = 0; m_next_end = n + W;
        end else if (bits_at(0, n - W - 1) == SYNC) begin
          m_locked = 1'b1; m_offset = 1; m_next_end = n - 1 + W;
        end
      end else if (n - m_offset == m_next_end) begin
        for (int k = 0; k < NL; k++) word[k*W +: W] = bits_at(k, m_next_end - W);
        m_next_end += W;
        if (word[W-1:0] != SYNC) begin
          new_pend    = 1'b1;
          m_pend_word = word;
        end
      end
    end
    m_pend = new_pend;
  endtask

  task automatic check_output();
    check_val("locked", 64'(locked), 64'(m_locked));
    check_val("out_valid", 64'(bus.out_valid), 64'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) check_val("out_data", 64'(bus.out_data), 64'(m_fifo[0]));
    check_val("overflow", 64'(overflow), 64'(m_overflow));
  endtask

  task automatic apply_stimulus(input bit iv, input logic [NL-1:0] r,
                                input logic [NL-1:0] f, input bit rl);
    bus.in_valid   = iv;
    bus.d_rise     = r;
    bus.d_fall     = f;
    realign        = rl;
    bus.out_ready  = cur_ready;
    clear_overflow = cur_clear;
    @(posedge clk);
    if (rst_n) model_edge();
    else model_reset();
    #1;
    check_output();
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) apply_stimulus(1'b0, NL'($urandom), NL'($urandom), 1'b0);
  endtask

  task automatic queue_word(input int k, input logic [W-1:0] v);
    for (int i = W - 1; i >= 0; i--) lane_q[k].push_back(v[i]);
  endtask

  task automatic queue_all(input logic [W-1:0] v0, input logic [W-1:0] v1,
                           input logic [W-1:0] v2);
    queue_word(0, v0);
    queue_word(1, v1);
    queue_word(2, v2);
  endtask

  // Sends lane-0 queued bits in pairs; lanes running short get random bits.
  task automatic send_queued(input int gap, input bit rl_last);
    logic [NL-1:0] r;
    logic [NL-1:0] f;
    bit            last;
    while (lane_q[0].size() >= 2) begin
      for (int k = 0; k < NL; k++) begin
        if (lane_q[k].size() >= 2) begin
          r[k] = lane_q[k].pop_front();
          f[k] = lane_q[k].pop_front();
        end else begin
          r[k] = 1'($urandom);
          f[k] = 1'($urandom);
        end
      end
      last = (lane_q[0].size() < 2);
      apply_stimulus(1'b1, r, f, rl_last && last);
      if (!last) idle(gap);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NL-1:0] r;
    logic [NL-1:0] f;
    bit            iv;
    bit            rl;

    rst_n = 1'b0;
    realign = 1'b0;
    clear_overflow = 1'b0;
    model_reset();

    // Reset held with random inputs.
    repeat (5) begin
      cur_ready = 1'($urandom);
      cur_clear = 1'($urandom);
      apply_stimulus(1'($urandom), NL'($urandom), NL'($urandom), 1'($urandom));
    end
    check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check_val("rst_locked", 64'(locked), 64'd0);
    check_val("rst_overflow", 64'(overflow), 64'd0);
    check_val("rst_out_data", 64'(bus.out_data), 64'd0);
    cur_ready = 1'b0;
    cur_clear = 1'b0;
    rst_n = 1'b1;

    // Lane 0 all ones: never a sync pattern.
    repeat (20) begin
      r = {2'($urandom), 1'b1};
      f = {2'($urandom), 1'b1};
      apply_stimulus(1'b1, r, f, 1'b0);
    end
    check_val("search_no_lock", 64'(locked), 64'd0);
    check_val("search_no_valid", 64'(bus.out_valid), 64'd0);

    // Offset-0 lock and first word latency.
    queue_all(SYNC, 8'h00, 8'h00);
    send_queued(0, 1'b0);
    check_val("lock_off0", 64'(locked), 64'd1);
    queue_all(8'h3C, 8'h11, 8'h22);
    send_queued(0, 1'b0);
    check_val("latency_edge_n", 64'(bus.out_valid), 64'd0);
    idle(1);
    check_val("latency_edge_n1", 64'(bus.out_valid), 64'd1);
    check_val("data_off0", 64'(bus.out_data), 64'h22113C);
    cur_ready = 1'b1; idle(1); cur_ready = 1'b0;

    // Offset-1 lock: one extra bit ahead of the stream, one pad bit after.
    apply_stimulus(1'b0, NL'($urandom), NL'($urandom), 1'b1);
    check_val("realign_to_search", 64'(locked), 64'd0);
    for (int k = 0; k < NL; k++) lane_q[k].push_back(1'b1);
    queue_all(SYNC, 8'h00, 8'h00);
    queue_all(8'h3C, 8'h11, 8'h22);
    for (int k = 0; k < NL; k++) lane_q[k].push_back(1'b1);
    send_queued(0, 1'b0);
    check_val("lock_off1", 64'(locked), 64'd1);
    idle(1);
    check_val("valid_off1", 64'(bus.out_valid), 64'd1);
    check_val("data_off1", 64'(bus.out_data), 64'h22113C);
    cur_ready = 1'b1; idle(1); cur_ready = 1'b0;

    // Idle drop, backpressure, overflow.
    apply_stimulus(1'b0, NL'($urandom), NL'($urandom), 1'b1);
    queue_all(SYNC, 8'($urandom), 8'($urandom));
    send_queued(0, 1'b0);
    queue_word(0, 8'h3C); queue_word(0, SYNC); queue_word(0, 8'h5A); queue_word(0, 8'h77);
    send_queued(0, 1'b0);
    idle(1);
    check_val("ovf_set", 64'(overflow), 64'd1);
    check_val("bp_head", 64'(bus.out_data[7:0]), 64'h3C);
    cur_ready = 1'b1;
    idle(1);
    check_val("bp_second", 64'(bus.out_data[7:0]), 64'h5A);
    idle(1);
    check_val("bp_drained", 64'(bus.out_valid), 64'd0);
    cur_ready = 1'b0;
    cur_clear = 1'b1; idle(1); cur_clear = 1'b0;
    check_val("ovf_clear", 64'(overflow), 64'd0);

    // Drop coinciding with clear: set wins.
    queue_word(0, 8'h12); queue_word(0, 8'h34); queue_word(0, 8'h56);
    cur_clear = 1'b1;
    send_queued(0, 1'b0);
    idle(1);
    cur_clear = 1'b0;
    check_val("ovf_set_wins", 64'(overflow), 64'd1);
    cur_ready = 1'b1; idle(2); cur_ready = 1'b0;
    cur_clear = 1'b1; idle(1); cur_clear = 1'b0;

    // in_valid gaps inside a word.
    queue_all(8'h96, 8'h4B, 8'hC3);
    send_queued(2, 1'b0);
    check_val("gap_edge_n", 64'(bus.out_valid), 64'd0);
    idle(1);
    check_val("gap_edge_n1", 64'(bus.out_valid), 64'd1);
    check_val("gap_data", 64'(bus.out_data), 64'hC34B96);
    cur_ready = 1'b1; idle(1); cur_ready = 1'b0;

    // realign keeps FIFO contents, then relock.
    queue_all(8'h66, 8'h01, 8'h02);
    send_queued(0, 1'b0);
    idle(1);
    apply_stimulus(1'b0, NL'($urandom), NL'($urandom), 1'b1);
    check_val("realign_unlock", 64'(locked), 64'd0);
    check_val("realign_keep_valid", 64'(bus.out_valid), 64'd1);
    check_val("realign_keep_data", 64'(bus.out_data), 64'h020166);
    cur_ready = 1'b1; idle(1); cur_ready = 1'b0;
    queue_all(SYNC, 8'h00, 8'h00);
    send_queued(0, 1'b0);
    check_val("relock", 64'(locked), 64'd1);
    queue_all(8'h3C, 8'hAA, 8'hBB);
    send_queued(0, 1'b0);
    idle(1);
    check_val("relock_data", 64'(bus.out_data), 64'hBBAA3C);
    cur_ready = 1'b1; idle(1); cur_ready = 1'b0;

    // realign on the completing sample suppresses that word.
    queue_all(8'h44, 8'h55, 8'h66);
    send_queued(0, 1'b1);
    check_val("realign_last_unlock", 64'(locked), 64'd0);
    idle(1);
    check_val("realign_last_drop", 64'(bus.out_valid), 64'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      cur_ready = ($urandom_range(0, 3) != 0);
      cur_clear = ($urandom_range(0, 15) == 0);
      rl = ($urandom_range(0, 63) == 0);
      iv = ($urandom_range(0, 3) != 0);
      r = NL'($urandom);
      f = NL'($urandom);
      if (iv) begin
        if (lane_q[0].size() < 2)
          queue_word(0, ($urandom_range(0, 2) == 0) ? SYNC : 8'($urandom));
        r[0] = lane_q[0].pop_front();
        f[0] = lane_q[0].pop_front();
      end
      apply_stimulus(iv, r, f, rl);
    end
    cur_clear = 1'b0;
    cur_ready = 1'b1; idle(3); cur_ready = 1'b0;

    // Asynchronous reset with a word waiting.
    for (int k = 0; k < NL; k++) lane_q[k].delete();
    apply_stimulus(1'b0, NL'($urandom), NL'($urandom), 1'b1);
    queue_all(8'hFF, 8'h00, 8'h00);
    queue_all(SYNC, 8'h00, 8'h00);
    queue_all(8'h3C, 8'h11, 8'h22);
    send_queued(0, 1'b0);
    idle(1);
    check_val("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_reset_valid", 64'(bus.out_valid), 64'd0);
    check_val("async_reset_locked", 64'(locked), 64'd0);
    model_reset();
    idle(2);
    rst_n = 1'b1;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
